micro_op_responder: RTL

Memory-side responder for the decoder's micro-instruction handshake. Accepts 32-bit micro-instruction words offered with `start`/`ready` and buffers them in a small FIFO. Executes each word in order against an accumulator and a single-port data-memory interface. It is the block that drives `ready_for_memory` back to the decoder.

---
 rtl/micro_op_responder_if.sv | 31 +++
 rtl/micro_op_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/micro_op_responder_if.sv
// micro_op_responder_if
//   Groups the decoder handshake and the data-memory bus of the
//   micro-instruction responder.
//   Decoder side : start, instruction_in (to responder), ready (from responder)
//   Memory side  : mem_req, mem_we, mem_addr, mem_wdata (from responder),
//                  mem_ack, mem_rdata (to responder)
//   slave  modport : the responder
//   master modport : whoever drives the decoder requests and the memory replies
interface micro_op_responder_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] instruction_in;
   logic             ready;
   logic             mem_req;
   logic             mem_we;
   logic [11:0]      mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;

   modport slave (
      input  start, instruction_in, mem_ack, mem_rdata,
      output ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output start, instruction_in, mem_ack, mem_rdata,
      input  ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/micro_op_responder.sv
// micro_op_responder
//   Accepts micro-instruction words from the decoder (start/ready), queues
//   them in a small FIFO and executes them in order against an accumulator
//   and a single-port data memory.
//   Ports:
//     clk, reset : single clock, synchronous active-high reset
//     bus        : handshake + memory bus (micro_op_responder_if.slave)
//     acc        : accumulator
//     busy       : FIFO non-empty or executor not idle
//     err        : sticky illegal-opcode flag
//     retired    : executed-word counter (NOP included), wraps at 2^16
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a queued word; pops the FIFO head into op_q
//   EXEC    | decodes op_q; register ops complete here
//   MEM     | memory request held stable until mem_ack
module micro_op_responder #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   micro_op_responder_if.slave        bus,
   output logic [WIDTH-1:0]           acc,
   output logic                       busy,
   output logic                       err,
   output logic [15:0]                retired
);

   localparam logic [3:0]  OP_NOP   = 4'd0;
   localparam logic [3:0]  OP_LOADI = 4'd1;
   localparam logic [3:0]  OP_ADDI  = 4'd2;
   localparam logic [3:0]  OP_LOAD  = 4'd3;
   localparam logic [3:0]  OP_STORE = 4'd4;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MEM  = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [WIDTH-1:0] fifo_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
   logic [AW:0]      count_q,     count_d;
   logic             ready_q,     ready_d;
   logic [WIDTH-1:0] op_q,        op_d;
   logic [WIDTH-1:0] acc_q,       acc_d;
   logic             err_q,       err_d;
   logic [15:0]      retired_q,   retired_d;
   logic             mem_req_q,   mem_req_d;
   logic             mem_we_q,    mem_we_d;
   logic [11:0]      mem_addr_q,  mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic             full;
   logic             push;
   logic             pop;
   logic [3:0]       op_code;
   logic [11:0]      op_addr;
   logic [WIDTH-1:0] op_imm;

   assign full    = (count_q == FULL_CNT);
   // ready_q high blocks acceptance so a request held through its own
   // acknowledge cycle is captured only once.
   assign push    = bus.start && !ready_q && !full;
   assign pop     = (state_q == ST_IDLE) && (count_q != '0);

   assign op_code = op_q[31:28];
   assign op_addr = op_q[27:16];
   assign op_imm  = {{(WIDTH-16){op_q[15]}}, op_q[15:0]};

   always_comb begin
      ready_d  = push;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      err_d       = err_q;
      retired_d   = retired_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               op_d    = fifo_q[rd_ptr_q];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            case (op_code)
               OP_NOP: begin
                  retired_d = retired_q + 16'd1;
               end
               OP_LOADI: begin
                  acc_d     = op_imm;
                  retired_d = retired_q + 16'd1;
               end
               OP_ADDI: begin
                  acc_d     = acc_q + op_imm;
                  retired_d = retired_q + 16'd1;
               end
               OP_LOAD, OP_STORE: begin
                  // Request fields are frozen here; the store data is the
                  // accumulator as it stands on entry to MEM.
                  state_d     = ST_MEM;
                  mem_req_d   = 1'b1;
                  mem_we_d    = (op_code == OP_STORE);
                  mem_addr_d  = op_addr;
                  mem_wdata_d = acc_q;
               end
               default: begin
                  err_d = 1'b1;
               end
            endcase
         end
         ST_MEM: begin
            if (bus.mem_ack) begin
               if (!mem_we_q) begin
                  acc_d = bus.mem_rdata;
               end
               retired_d = retired_q + 16'd1;
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ready_q     <= 1'b0;
         op_q        <= '0;
         acc_q       <= '0;
         err_q       <= 1'b0;
         retired_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.instruction_in;
         end
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ready_q     <= ready_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         err_q       <= err_d;
         retired_q   <= retired_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign bus.ready     = ready_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign acc           = acc_q;
   assign err           = err_q;
   assign retired       = retired_q;
   assign busy          = (count_q != '0) || (state_q != ST_IDLE);

endmodule
